// File: rtl/poly_note_player_pkg.sv
// Shared definitions for the three-voice note player: default widths,
// the rest note code and the per-voice FSM state encoding.
package poly_note_player_pkg;

  localparam int NOTE_W_DEFAULT = 6;
  localparam int DUR_W_DEFAULT  = 6;
  localparam int NUM_VOICES     = 3;

  // Note code 0 is a rest: timed like any note, but silent downstream.
  localparam int REST_NOTE = 0;

  typedef enum logic {
    IDLE    = 1'b0,
    PLAYING = 1'b1
  } voice_state_e;

endpackage

// File: rtl/poly_note_player_voice_timer.sv
// One voice of the note player: latches note/duration on new_note, counts
// qualifying beats (beat && play) down, and flags note_done on expiry.
// NOTE_PLAYER_DONE_HOLD_EN: when defined, note_done is held high from expiry
// until the next new_note for this voice instead of being a 1-cycle pulse.
module voice_timer
  import poly_note_player_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEFAULT,
  parameter int DUR_W  = DUR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              beat,
  input  logic              new_note,
  input  logic [NOTE_W-1:0] note,
  input  logic [DUR_W-1:0]  duration,
  output logic              note_done,
  output logic              active,
  output logic [NOTE_W-1:0] cur_note
);

  voice_state_e      state, state_nxt;
  logic [NOTE_W-1:0] note_q, note_nxt;
  logic [DUR_W-1:0]  remaining, remaining_nxt;
  logic              done_q, done_nxt;

  // Next-state: a load always wins over a beat or an expiry in the same cycle,
  // so a preempted or colliding note never produces a done.
  always_comb begin
    state_nxt     = state;
    note_nxt      = note_q;
    remaining_nxt = remaining;
`ifdef NOTE_PLAYER_DONE_HOLD_EN
    done_nxt      = done_q;
`else
    done_nxt      = 1'b0;
`endif
    if (new_note) begin
      note_nxt      = note;
      remaining_nxt = duration;
      if (duration == '0) begin
        // Zero-length note completes immediately without ever going active.
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = PLAYING;
        done_nxt  = 1'b0;
      end
    end else if (state == PLAYING && play && beat) begin
      if (remaining == DUR_W'(1)) begin
        // Expiry is caught at 1, so the counter never wraps below zero.
        state_nxt     = IDLE;
        remaining_nxt = '0;
        note_nxt      = NOTE_W'(REST_NOTE);
        done_nxt      = 1'b1;
      end else begin
        remaining_nxt = remaining - DUR_W'(1);
      end
    end
  end

  // State register; reset aborts any note in flight with no done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      note_q    <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      note_q    <= note_nxt;
      remaining <= remaining_nxt;
      done_q    <= done_nxt;
    end
  end

  assign active    = (state == PLAYING);
  assign cur_note  = active ? note_q : NOTE_W'(REST_NOTE);
  assign note_done = done_q;

endmodule

// File: rtl/poly_note_player.sv
// Three-voice note player: times each voice's note against the beat strobe
// and returns per-voice done indications to the song reader.
// NOTE_PLAYER_DONE_HOLD_EN: level-held note_done (see voice_timer).
module poly_note_player
  import poly_note_player_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEFAULT,
  parameter int DUR_W  = DUR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              beat,
  input  logic [NOTE_W-1:0] note_one,
  input  logic [NOTE_W-1:0] note_two,
  input  logic [NOTE_W-1:0] note_three,
  input  logic [DUR_W-1:0]  duration_one,
  input  logic [DUR_W-1:0]  duration_two,
  input  logic [DUR_W-1:0]  duration_three,
  input  logic              new_note_one,
  input  logic              new_note_two,
  input  logic              new_note_three,
  output logic              note_one_done,
  output logic              note_two_done,
  output logic              note_three_done,
  output logic [NOTE_W-1:0] cur_note_one,
  output logic [NOTE_W-1:0] cur_note_two,
  output logic [NOTE_W-1:0] cur_note_three,
  output logic              active_one,
  output logic              active_two,
  output logic              active_three,
  output logic              all_idle
);

  logic [NUM_VOICES-1:0][NOTE_W-1:0] note_v, cur_note_v;
  logic [NUM_VOICES-1:0][DUR_W-1:0]  dur_v;
  logic [NUM_VOICES-1:0]             new_v, done_v, active_v;

  assign note_v = {note_three, note_two, note_one};
  assign dur_v  = {duration_three, duration_two, duration_one};
  assign new_v  = {new_note_three, new_note_two, new_note_one};

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    voice_timer #(
      .NOTE_W (NOTE_W),
      .DUR_W  (DUR_W)
    ) u_voice (
      .clk       (clk),
      .reset     (reset),
      .play      (play),
      .beat      (beat),
      .new_note  (new_v[v]),
      .note      (note_v[v]),
      .duration  (dur_v[v]),
      .note_done (done_v[v]),
      .active    (active_v[v]),
      .cur_note  (cur_note_v[v])
    );
  end

  assign note_one_done   = done_v[0];
  assign note_two_done   = done_v[1];
  assign note_three_done = done_v[2];
  assign cur_note_one    = cur_note_v[0];
  assign cur_note_two    = cur_note_v[1];
  assign cur_note_three  = cur_note_v[2];
  assign active_one      = active_v[0];
  assign active_two      = active_v[1];
  assign active_three    = active_v[2];
  assign all_idle        = ~|active_v;

endmodule
